// File: rtl/cmd_combo_queue.sv
`default_nettype none
// ============================================================================
// Module   : cmd_combo_queue
// Purpose  : Detects DOWN-RIGHT-PUNCH (FIREBALL) and DOWN-LEFT-KICK (SWEEP)
//            in the keyboard command stream and queues actions for game logic.
//            Define COMBO_EN to build the combo FSM and window timer.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_combo_queue #(
    parameter int TIMEOUT_CYCLES = 25_000_000,
    parameter int TMR_W          = 25,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    cmd,
    input  logic                          act_ready,
    output logic                          act_valid,
    output logic [3:0]                    act_code,
    output logic                          act_combo,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int              c_AW       = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_FULL     = FIFO_DEPTH[c_AW:0];
    localparam logic [c_AW:0]   c_CNT_ONE  = 1;
    localparam logic [c_AW-1:0] c_PTR_ONE  = 1;
    localparam logic [3:0]      c_LEFT     = 4'd0;
    localparam logic [3:0]      c_RIGHT    = 4'd1;
    localparam logic [3:0]      c_DOWN     = 4'd2;
    localparam logic [3:0]      c_PUNCH    = 4'd5;
    localparam logic [3:0]      c_KICK     = 4'd7;
    localparam logic [3:0]      c_FIREBALL = 4'd8;
    localparam logic [3:0]      c_SWEEP    = 4'd9;
    localparam logic [3:0]      c_EMPTY    = 4'hF;

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("cmd_combo_queue: FIFO_DEPTH must be a power of two >= 2");
        end
        if ((64'd1 << TMR_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_tmr
            $error("cmd_combo_queue: TMR_W too narrow for TIMEOUT_CYCLES");
        end
    endgenerate

    logic       w_cmd_vld;
    logic [3:0] w_push_code;

    // Codes 8-15 all behave as idle.
    assign w_cmd_vld = ~cmd[3];

`ifdef COMBO_EN
    localparam logic [1:0]       c_IDLE     = 2'd0;
    localparam logic [1:0]       c_S_D      = 2'd1;
    localparam logic [1:0]       c_S_DR     = 2'd2;
    localparam logic [1:0]       c_S_DL     = 2'd3;
    localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] c_TMR_ONE  = 1;

    logic [1:0]       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        w_push_code = cmd;
        if (w_cmd_vld) begin
            tmr_d = '0;
            if (cmd == c_DOWN) begin
                state_d = c_S_D;
            end else begin
                state_d = c_IDLE;
                case (state_q)
                    c_S_D: begin
                        if (cmd == c_RIGHT)     state_d = c_S_DR;
                        else if (cmd == c_LEFT) state_d = c_S_DL;
                    end
                    c_S_DR:  if (cmd == c_PUNCH) w_push_code = c_FIREBALL;
                    c_S_DL:  if (cmd == c_KICK)  w_push_code = c_SWEEP;
                    default: ;
                endcase
            end
        end else if (state_q != c_IDLE) begin
            // Last in-window cycle is TIMEOUT_CYCLES after the previous key.
            if (tmr_q == c_TMR_LAST) begin
                state_d = c_IDLE;
                tmr_d   = '0;
            end else begin
                tmr_d = tmr_q + c_TMR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    assign act_combo = act_valid & act_code[3];
`else
    assign w_push_code = cmd;
    assign act_combo   = 1'b0;
`endif

    logic [3:0]      mem_q [FIFO_DEPTH];
    logic [3:0]      mem_d [FIFO_DEPTH];
    logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_AW:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            w_full, w_pop, w_push;

    always_comb begin
        w_full   = (cnt_q == c_FULL);
        w_pop    = (cnt_q != '0) & act_ready;
        // A pop in the same cycle frees the slot, so a full queue can still accept.
        w_push   = w_cmd_vld & (~w_full | w_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q | (w_cmd_vld & w_full & ~w_pop);
        if (w_push) begin
            mem_d[wr_ptr_q] = w_push_code;
            wr_ptr_d        = wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
        if (w_push && !w_pop)      cnt_d = cnt_q + c_CNT_ONE;
        else if (!w_push && w_pop) cnt_d = cnt_q - c_CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= c_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    assign act_valid = (cnt_q != '0);
    assign act_code  = act_valid ? mem_q[rd_ptr_q] : c_EMPTY;
    assign level     = cnt_q;
    assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_combo_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_combo_queue
// Purpose  : Self-checking bench for cmd_combo_queue: queue/history reference
//            model compared every cycle, plus literal stream expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_combo_queue;

    localparam int T     = 100;
    localparam int TW    = 7;
    localparam int DEPTH = 4;
`ifdef COMBO_EN
    localparam bit COMBO_ON = 1'b1;
`else
    localparam bit COMBO_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cmd = 4'hF;
    logic       act_ready = 1'b0;
    logic       act_valid;
    logic [3:0] act_code;
    logic       act_combo;
    logic [2:0] level;
    logic       overflow;

    always #5 clk = ~clk;

    cmd_combo_queue #(
        .TIMEOUT_CYCLES (T),
        .TMR_W          (TW),
        .FIFO_DEPTH     (DEPTH)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd),
        .act_ready (act_ready),
        .act_valid (act_valid),
        .act_code  (act_code),
        .act_combo (act_combo),
        .level     (level),
        .overflow  (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of actions plus the last two accepted keys
    // with their arrival cycles; a combo needs D,R,P or D,L,K with each gap <= T.
    int     mq[$];
    bit     m_ovf;
    int     h_code[2];
    longint h_time[2];
    int     h_n;
    longint cyc = 0;
    bit     started = 1'b0;
    int     m_code;
    bit     m_combo;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            h_n   = 0;
        end else begin
            if (mq.size() > 0 && act_ready) void'(mq.pop_front());
            if (cmd < 4'd8) begin
                m_code  = int'(cmd);
                m_combo = 1'b0;
                if (COMBO_ON && h_n == 2 && h_code[0] == 2 &&
                    (h_time[1] - h_time[0]) <= T && (cyc - h_time[1]) <= T) begin
                    if (h_code[1] == 1 && cmd == 4'd5) begin m_code = 8; m_combo = 1'b1; end
                    if (h_code[1] == 0 && cmd == 4'd7) begin m_code = 9; m_combo = 1'b1; end
                end
                if (mq.size() < DEPTH) mq.push_back(m_code);
                else                   m_ovf = 1'b1;
                if (m_combo) begin
                    h_n = 0;
                end else if (h_n < 2) begin
                    h_code[h_n] = int'(cmd);
                    h_time[h_n] = cyc;
                    h_n++;
                end else begin
                    h_code[0] = h_code[1];
                    h_time[0] = h_time[1];
                    h_code[1] = int'(cmd);
                    h_time[1] = cyc;
                end
            end
        end
        started = 1'b1;
    end

    logic [4:0] popped[$];
    logic [4:0] exp_q[$];

    always @(negedge clk) begin
        if (started) begin
            check("act_valid", act_valid, mq.size() > 0);
            check("act_code",  act_code,  (mq.size() > 0) ? mq[0] : 15);
            check("act_combo", act_combo, (mq.size() > 0) && (mq[0] >= 8));
            check("level",     level,     mq.size());
            check("overflow",  overflow,  m_ovf);
            if (!rst && act_valid && act_ready) popped.push_back({act_combo, act_code});
        end
    end

    function automatic logic [4:0] cmb(input int combo_code, input int raw_code);
        return COMBO_ON ? {1'b1, 4'(combo_code)} : {1'b0, 4'(raw_code)};
    endfunction

    task automatic check_stream(input string name);
        check({name, " length"}, popped.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check(name, (i < popped.size()) ? {27'd0, popped[i]} : 32'hDEAD, {27'd0, exp_q[i]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] c);
        cmd = c;
        tick();
        cmd = 4'hF;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [3:0] pick [16] = '{4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0, 4'd5,
                              4'd5, 4'd7, 4'd7, 4'd3, 4'd4, 4'd6, 4'd9, 4'd14};

    initial begin
        rst = 1'b1; cmd = 4'hF; act_ready = 1'b0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset act_valid", act_valid, 0);
        check("reset act_code",  act_code,  15);
        check("reset level",     level,     0);
        check("reset overflow",  overflow,  0);

        // D,R,P 10 cycles apart
        act_ready = 1'b1;
        popped.delete();
        send(4'd2); idle(9); send(4'd1); idle(9); send(4'd5); idle(3);
        exp_q = '{5'h02, 5'h01, cmb(8, 5)};
        check_stream("fireball");

        // D, L after 101 cycles (window expired), K
        popped.delete();
        send(4'd2); idle(100); send(4'd0); idle(4); send(4'd7); idle(3);
        exp_q = '{5'h02, 5'h00, 5'h07};
        check_stream("sweep_late");

        // Same with gap of exactly 100
        popped.delete();
        send(4'd2); idle(99); send(4'd0); idle(4); send(4'd7); idle(3);
        exp_q = '{5'h02, 5'h00, cmb(9, 7)};
        check_stream("sweep_edge");

        popped.delete();
        send(4'd2); send(4'd2); send(4'd1); send(4'd5); idle(3);
        exp_q = '{5'h02, 5'h02, 5'h01, cmb(8, 5)};
        check_stream("double_down");

        // Fill and overflow
        pulse_rst();
        act_ready = 1'b0;
        send(4'd3); send(4'd4); send(4'd6); send(4'd7); send(4'd0);
        @(negedge clk);
        check("full level",    level,    4);
        check("full overflow", overflow, 1);
        popped.delete();
        act_ready = 1'b1;
        idle(6);
        exp_q = '{5'h03, 5'h04, 5'h06, 5'h07};
        check_stream("drain");
        @(negedge clk);
        check("drained act_code",  act_code,  15);
        check("drained act_valid", act_valid, 0);
        check("overflow sticky",   overflow,  1);

        // Push and pop together while full
        pulse_rst();
        act_ready = 1'b0;
        popped.delete();
        send(4'd3); send(4'd4); send(4'd6); send(4'd7);
        act_ready = 1'b1;
        send(4'd5);
        act_ready = 1'b0;
        @(negedge clk);
        check("full pushpop level",    level,    4);
        check("full pushpop overflow", overflow, 0);
        act_ready = 1'b1;
        idle(6);
        exp_q = '{5'h03, 5'h04, 5'h06, 5'h07, 5'h05};
        check_stream("full_pushpop");

        // Reset mid-sequence
        act_ready = 1'b0;
        send(4'd2); send(4'd1);
        pulse_rst();
        @(negedge clk);
        check("midseq reset level", level, 0);
        popped.delete();
        act_ready = 1'b1;
        send(4'd5); idle(3);
        exp_q = '{5'h05};
        check_stream("after_reset");

        // Randomized phase; every cycle is checked against the model
        for (int it = 0; it < 4000; it++) begin
            cmd       = ($urandom_range(0, 99) < 45) ? 4'hF : pick[$urandom_range(0, 15)];
            act_ready = ($urandom_range(0, 3) != 0) ^ ((it / 64) % 4 == 3);
            rst       = ($urandom_range(0, 299) == 0);
            tick();
            if ($urandom_range(0, 99) < 3) begin
                cmd = 4'hF;
                rst = 1'b0;
                idle($urandom_range(T - 3, T + 1));
            end
        end
        cmd = 4'hF; rst = 1'b0; act_ready = 1'b1;
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
